encoder_sample_ctrl: RTL and testbench

Controller that sequences a quadrature position decoder: it homes the decoder by pulsing the decoder's synchronous clear, waits for the decoder pipeline to settle, then periodically samples the 32-bit signed position. Each sample carries the position and its delta since the previous sample (a velocity estimate), delivered over a valid/ready handshake. It sits between the decoder and the motion-control consumer (a software-visible register block or a speed loop).

---
 rtl/encoder_sample_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_encoder_sample_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_sample_ctrl.sv
// Quadrature decoder sequencer: homes via dec_clr, settles, then emits periodic
// position/delta samples. Optional soft position limit under `ENC_CTRL_LIMIT_EN.
module encoder_sample_ctrl #(
  parameter int PERIOD     = 1000,
  parameter int SETTLE_CYC = 4,
  parameter int LIMIT      = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        home_req,
  input  logic        ovr_clr,
  input  logic [31:0] position,
  output logic        dec_clr,
  output logic        smp_valid,
  input  logic        smp_ready,
  output logic [31:0] smp_pos,
  output logic [31:0] smp_delta,
  output logic        overrun,
  output logic        homed,
  output logic        limit_fault,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } state_e;

  localparam int TW = $clog2(PERIOD);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam logic [TW-1:0] TICK_LAST   = TW'(PERIOD - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [SW-1:0] settle_cnt_q, settle_cnt_d;
  logic [31:0]   prev_q, prev_d;
  logic [31:0]   smp_pos_q, smp_pos_d;
  logic [31:0]   smp_delta_q, smp_delta_d;
  logic          smp_valid_q, smp_valid_d;
  logic          overrun_q, overrun_d;
  logic          homed_q, homed_d;
  logic          dec_clr_q, dec_clr_d;
  logic          limit_fault_q;

  logic tick;
  logic settle_done;
  logic settle_exit;
  logic limit_hit;

  assign tick        = (state_q == ST_RUN) && (tick_cnt_q == TICK_LAST);
  assign settle_done = (state_q == ST_SETTLE) && (settle_cnt_q == SETTLE_LAST);
  assign settle_exit = settle_done && !home_req;

`ifdef ENC_CTRL_LIMIT_EN
  localparam logic signed [31:0] LIM_P = 32'(LIMIT);
  localparam logic signed [31:0] LIM_N = -LIM_P;

  logic limit_fault_d;

  assign limit_hit = tick && (($signed(position) > LIM_P) || ($signed(position) < LIM_N));

  always_comb begin
    limit_fault_d = limit_fault_q;
    if (home_req) begin
      limit_fault_d = 1'b0;
    end else if (limit_hit) begin
      limit_fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      limit_fault_q <= 1'b0;
    end else begin
      limit_fault_q <= limit_fault_d;
    end
  end
`else
  logic unused_limit;

  assign limit_hit     = 1'b0;
  assign limit_fault_q = 1'b0;
  assign unused_limit  = ^LIMIT;
`endif

  // home_req overrides everything; a limit hit beats enable in RUN.
  always_comb begin
    state_d = state_q;
    if (home_req) begin
      state_d = ST_CLEAR;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable && !limit_fault_q) state_d = ST_RUN;
        end
        ST_CLEAR: begin
          state_d = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_done) state_d = enable ? ST_RUN : ST_IDLE;
        end
        ST_RUN: begin
          if (limit_hit || !enable) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Handshake: a sample is held stable while smp_valid=1 and is consumed on a
  // cycle with smp_valid && smp_ready; a tick in that cycle reloads it instead.
  // A tick while smp_valid && !smp_ready overwrites the sample and sets overrun.
  always_comb begin
    tick_cnt_d   = '0;
    settle_cnt_d = '0;
    prev_d       = prev_q;
    smp_pos_d    = smp_pos_q;
    smp_delta_d  = smp_delta_q;
    smp_valid_d  = smp_valid_q;
    overrun_d    = overrun_q;
    homed_d      = homed_q | settle_exit;
    dec_clr_d    = (state_d == ST_CLEAR);

    if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    end
    if ((state_q == ST_SETTLE) && (state_d == ST_SETTLE)) begin
      settle_cnt_d = settle_cnt_q + 1'b1;
    end

    if (settle_exit) begin
      prev_d = '0;
    end else if ((state_q == ST_IDLE) && (state_d == ST_RUN)) begin
      prev_d = position;
    end else if (tick) begin
      prev_d = position;
    end

    if (smp_valid_q && smp_ready) begin
      smp_valid_d = 1'b0;
    end
    if (tick) begin
      smp_valid_d = 1'b1;
      smp_pos_d   = position;
      smp_delta_d = position - prev_q;
    end

    if (ovr_clr || home_req) begin
      overrun_d = 1'b0;
    end
    if (tick && smp_valid_q && !smp_ready) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      tick_cnt_q   <= '0;
      settle_cnt_q <= '0;
      prev_q       <= '0;
      smp_pos_q    <= '0;
      smp_delta_q  <= '0;
      smp_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
      homed_q      <= 1'b0;
      dec_clr_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      prev_q       <= prev_d;
      smp_pos_q    <= smp_pos_d;
      smp_delta_q  <= smp_delta_d;
      smp_valid_q  <= smp_valid_d;
      overrun_q    <= overrun_d;
      homed_q      <= homed_d;
      dec_clr_q    <= dec_clr_d;
    end
  end

  assign dec_clr     = dec_clr_q;
  assign smp_valid   = smp_valid_q;
  assign smp_pos     = smp_pos_q;
  assign smp_delta   = smp_delta_q;
  assign overrun     = overrun_q;
  assign homed       = homed_q;
  assign limit_fault = limit_fault_q;
  assign state       = state_q;

endmodule

// File: tb/tb_encoder_sample_ctrl.sv
// Directed bench for encoder_sample_ctrl with PERIOD=8, SETTLE_CYC=4, LIMIT=1000;
// limit expectations follow whether ENC_CTRL_LIMIT_EN is defined.
module tb_encoder_sample_ctrl;

`ifdef ENC_CTRL_LIMIT_EN
  localparam bit LIM_EN = 1'b1;
`else
  localparam bit LIM_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        home_req;
  logic        ovr_clr;
  logic [31:0] position;
  logic        dec_clr;
  logic        smp_valid;
  logic        smp_ready;
  logic [31:0] smp_pos;
  logic [31:0] smp_delta;
  logic        overrun;
  logic        homed;
  logic        limit_fault;
  logic [1:0]  state;

  int n_checks;
  int n_fail;
  bit ramp;
  logic [31:0] exp_q[$];

  encoder_sample_ctrl #(
    .PERIOD    (8),
    .SETTLE_CYC(4),
    .LIMIT     (1000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .home_req   (home_req),
    .ovr_clr    (ovr_clr),
    .position   (position),
    .dec_clr    (dec_clr),
    .smp_valid  (smp_valid),
    .smp_ready  (smp_ready),
    .smp_pos    (smp_pos),
    .smp_delta  (smp_delta),
    .overrun    (overrun),
    .homed      (homed),
    .limit_fault(limit_fault),
    .state      (state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (ramp) position = position + 32'd1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_sample(input string tag, input logic [31:0] exp_delta);
    logic [31:0] exp_pos;
    check({tag, "_valid"}, 32'(smp_valid), 32'd1);
    check({tag, "_have_exp"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      exp_pos = exp_q.pop_front();
      check({tag, "_pos"}, smp_pos, exp_pos);
    end
    check({tag, "_delta"}, smp_delta, exp_delta);
  endtask

  task automatic consume(input string tag);
    smp_ready = 1'b1;
    step();
    smp_ready = 1'b0;
    check({tag, "_consumed"}, 32'(smp_valid), 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    ramp      = 1'b0;
    rst_n     = 1'b0;
    enable    = 1'b0;
    home_req  = 1'b0;
    ovr_clr   = 1'b0;
    smp_ready = 1'b0;
    position  = 32'd0;
    exp_q = '{32'd0, 32'd1013, 32'd100, 32'd150, 32'd170, 32'h8000_0001, 32'hFFFF_FC17};

    // reset values
    steps(2);
    check("rst_state", 32'(state), 32'd0);
    check("rst_dec_clr", 32'(dec_clr), 32'd0);
    check("rst_valid", 32'(smp_valid), 32'd0);
    check("rst_flags", {29'd0, overrun, homed, limit_fault}, 32'd0);
    check("rst_pos", smp_pos, 32'd0);
    check("rst_delta", smp_delta, 32'd0);

    // IDLE -> RUN, first sample after 8 RUN cycles
    rst_n  = 1'b1;
    enable = 1'b1;
    step();
    check("run_state", 32'(state), 32'd3);
    steps(7);
    check("t1_not_yet", 32'(smp_valid), 32'd0);
    step();
    check_sample("t1", 32'd0);
    check("t1_homed", 32'(homed), 32'd0);
    consume("t1");

    // homing with a ramping position
    position = 32'd1000;
    ramp     = 1'b1;
    home_req = 1'b1;
    step();
    home_req = 1'b0;
    check("home_s1", 32'(state), 32'd1);
    check("home_dec_clr1", 32'(dec_clr), 32'd1);
    step();
    check("home_s2", 32'(state), 32'd2);
    check("home_dec_clr0", 32'(dec_clr), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("home_settle", 32'(state), 32'd2);
    end
    check("home_not_homed", 32'(homed), 32'd0);
    step();
    check("home_run", 32'(state), 32'd3);
    check("home_homed", 32'(homed), 32'd1);
    steps(7);
    check("t2_not_yet", 32'(smp_valid), 32'd0);
    step();
    check_sample("t2", 32'd1013);
    ramp = 1'b0;
    consume("t2");

    // overrun: two ticks without ready
    position = 32'd100;
    steps(6);
    step();
    check_sample("t3", 32'hFFFF_FC6F);
    check("t3_ovr", 32'(overrun), 32'd0);
    position = 32'd150;
    steps(8);
    check_sample("t4", 32'd50);
    check("t4_ovr", 32'(overrun), 32'd1);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    check("ovr_clr", 32'(overrun), 32'd0);
    check("t4_hold_valid", 32'(smp_valid), 32'd1);
    check("t4_hold_pos", smp_pos, 32'd150);

    // tick coincident with a consume
    position = 32'd170;
    steps(6);
    smp_ready = 1'b1;
    step();
    smp_ready = 1'b0;
    check_sample("t5", 32'd20);
    check("t5_ovr", 32'(overrun), 32'd0);
    step();
    check("t5_still_valid", 32'(smp_valid), 32'd1);
    consume("t5");

    // two's-complement wrap of the delta
    enable = 1'b0;
    step();
    check("wrap_idle", 32'(state), 32'd0);
    position = 32'h7FFF_FFFF;
    enable   = 1'b1;
    step();
    check("wrap_run", 32'(state), 32'd3);
    position = 32'h8000_0001;
    steps(8);
    check_sample("t6", 32'd2);
    check("t6_fault", 32'(limit_fault), 32'(LIM_EN));
    check("t6_state", 32'(state), LIM_EN ? 32'd0 : 32'd3);
    consume("t6");

    // re-home clears any fault, then a tick beyond -LIMIT
    position = 32'hFFFF_FC17;
    home_req = 1'b1;
    step();
    home_req = 1'b0;
    check("rehome_state", 32'(state), 32'd1);
    check("rehome_fault", 32'(limit_fault), 32'd0);
    steps(5);
    check("rehome_run", 32'(state), 32'd3);
    steps(8);
    check_sample("t7", 32'hFFFF_FC17);
    check("t7_fault", 32'(limit_fault), 32'(LIM_EN));
    check("t7_state", 32'(state), LIM_EN ? 32'd0 : 32'd3);
    step();
    check("t7_stay", 32'(state), LIM_EN ? 32'd0 : 32'd3);

    // asynchronous reset in SETTLE with a sample pending
    home_req = 1'b1;
    step();
    home_req = 1'b0;
    check("t8_fault_clr", 32'(limit_fault), 32'd0);
    step();
    check("t8_settle", 32'(state), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_state", 32'(state), 32'd0);
    check("arst_dec_clr", 32'(dec_clr), 32'd0);
    check("arst_valid", 32'(smp_valid), 32'd0);
    check("arst_pos", smp_pos, 32'd0);
    check("arst_delta", smp_delta, 32'd0);
    check("arst_flags", {29'd0, overrun, homed, limit_fault}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
